// File: rtl/tl_pkg.sv
// Shared TileLink-UL constants: channel widths and A/D opcode encodings.
package tl_pkg;

  localparam int TL_ADDR_W = 33;
  localparam int TL_DATA_W = 64;
  localparam int TL_MASK_W = 8;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH       = 3'd2;
  localparam logic [2:0] LOGIC       = 3'd3;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] INTENT      = 3'd5;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] HINT_ACK        = 3'd2;

  // Low address bits that must be zero for a naturally aligned beat of 2**size bytes.
  function automatic logic [2:0] size_low_mask(input logic [3:0] size);
    case (size)
      4'd0:    size_low_mask = 3'b000;
      4'd1:    size_low_mask = 3'b001;
      4'd2:    size_low_mask = 3'b011;
      default: size_low_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/tl_a_decode.sv
// Combinational A-channel decode: address window / alignment check and
// the response class (opcode, denied, corrupt, data/write enables).
module tl_a_decode
  import tl_pkg::*;
#(
  parameter logic [TL_ADDR_W-1:0] BASE_ADDR = 33'h0_0001_0000,
  parameter int                   DEPTH     = 16,
  parameter int                   IDX_W     = $clog2(DEPTH)
) (
  input  logic [2:0]           opcode,
  input  logic [TL_ADDR_W-1:0] address,
  input  logic [3:0]           size,
  input  logic                 corrupt,
  output logic [IDX_W-1:0]     idx,
  output logic [2:0]           d_opcode,
  output logic                 denied,
  output logic                 d_corrupt,
  output logic                 data_en,
  output logic                 write_en
);

  localparam logic [TL_ADDR_W-1:0] WINDOW = TL_ADDR_W'(DEPTH * 8);

  logic [TL_ADDR_W-1:0] offset;
  logic                 in_range;
  logic                 aligned;
  logic                 ok;

  // The explicit lower-bound test keeps wrapped offsets from aliasing into the window.
  assign offset   = address - BASE_ADDR;
  assign in_range = (address >= BASE_ADDR) && (offset < WINDOW);
  assign aligned  = (size <= 4'd3) && ((address[2:0] & size_low_mask(size)) == 3'd0);
  assign ok       = in_range && aligned;
  assign idx      = offset[IDX_W+2:3];

  always_comb begin
    d_opcode  = ACCESS_ACK;
    denied    = 1'b1;
    d_corrupt = 1'b0;
    data_en   = 1'b0;
    write_en  = 1'b0;
    case (opcode)
      GET: begin
        d_opcode  = ACCESS_ACK_DATA;
        denied    = ~ok;
        d_corrupt = ~ok;
        data_en   = ok;
      end
      PUT_FULL, PUT_PARTIAL: begin
        denied   = ~ok | corrupt;
        write_en = ok & ~corrupt;
      end
      ARITH, LOGIC: begin
        d_opcode  = ACCESS_ACK_DATA;
        d_corrupt = 1'b1;
      end
      INTENT: begin
        d_opcode = HINT_ACK;
        denied   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tl_ram_responder.sv
// TileLink-UL single-beat manager backed by a small 64-bit register memory;
// one response register, refilled in the same cycle it drains.
module tl_ram_responder
  import tl_pkg::*;
#(
  parameter logic [TL_ADDR_W-1:0] BASE_ADDR = 33'h0_0001_0000,
  parameter int                   DEPTH     = 16,
  parameter int                   SOURCE_W  = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 a_ready,
  input  logic                 a_valid,
  input  logic [2:0]           a_opcode,
  input  logic [2:0]           a_param,
  input  logic [3:0]           a_size,
  input  logic [SOURCE_W-1:0]  a_source,
  input  logic [TL_ADDR_W-1:0] a_address,
  input  logic [TL_MASK_W-1:0] a_mask,
  input  logic [TL_DATA_W-1:0] a_data,
  input  logic                 a_corrupt,
  input  logic                 d_ready,
  output logic                 d_valid,
  output logic [2:0]           d_opcode,
  output logic [1:0]           d_param,
  output logic [3:0]           d_size,
  output logic [SOURCE_W-1:0]  d_source,
  output logic                 d_sink,
  output logic                 d_denied,
  output logic [TL_DATA_W-1:0] d_data,
  output logic                 d_corrupt
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [TL_DATA_W-1:0] mem [DEPTH];

  logic                 a_fire;
  logic [IDX_W-1:0]     dec_idx;
  logic [2:0]           dec_opcode;
  logic                 dec_denied;
  logic                 dec_corrupt;
  logic                 dec_data_en;
  logic                 dec_write_en;
  logic [TL_DATA_W-1:0] wr_bits;
  logic                 unused_a_param;

  logic                 d_valid_reg;
  logic [2:0]           d_opcode_reg;
  logic [3:0]           d_size_reg;
  logic [SOURCE_W-1:0]  d_source_reg;
  logic                 d_denied_reg;
  logic [TL_DATA_W-1:0] d_data_reg;
  logic                 d_corrupt_reg;

  tl_a_decode #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_decode (
    .opcode    (a_opcode),
    .address   (a_address),
    .size      (a_size),
    .corrupt   (a_corrupt),
    .idx       (dec_idx),
    .d_opcode  (dec_opcode),
    .denied    (dec_denied),
    .d_corrupt (dec_corrupt),
    .data_en   (dec_data_en),
    .write_en  (dec_write_en)
  );

  assign a_ready        = ~d_valid_reg | d_ready;
  assign a_fire         = a_valid & a_ready;
  assign unused_a_param = ^a_param;

  generate
    for (genvar gi = 0; gi < TL_MASK_W; gi++) begin : g_lane
      assign wr_bits[gi*8 +: 8] = {8{dec_write_en & a_mask[gi]}};
    end
  endgenerate

  // Read for the response register samples mem before this edge's write lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_valid_reg   <= 1'b0;
      d_opcode_reg  <= '0;
      d_size_reg    <= '0;
      d_source_reg  <= '0;
      d_denied_reg  <= 1'b0;
      d_data_reg    <= '0;
      d_corrupt_reg <= 1'b0;
    end else if (a_fire) begin
      d_valid_reg   <= 1'b1;
      d_opcode_reg  <= dec_opcode;
      d_size_reg    <= a_size;
      d_source_reg  <= a_source;
      d_denied_reg  <= dec_denied;
      d_data_reg    <= dec_data_en ? mem[dec_idx] : '0;
      d_corrupt_reg <= dec_corrupt;
    end else if (d_ready) begin
      d_valid_reg   <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else if (a_fire && dec_write_en) begin
      mem[dec_idx] <= (mem[dec_idx] & ~wr_bits) | (a_data & wr_bits);
    end
  end

  assign d_valid   = d_valid_reg;
  assign d_opcode  = d_opcode_reg;
  assign d_param   = 2'd0;
  assign d_size    = d_size_reg;
  assign d_source  = d_source_reg;
  assign d_sink    = 1'b0;
  assign d_denied  = d_denied_reg;
  assign d_data    = d_data_reg;
  assign d_corrupt = d_corrupt_reg;

endmodule

// File: doc/tl_ram_responder.md
Name: tl_ram_responder

Overview:
- TileLink-UL responder (manager end): consumes A-channel requests from the existing 2-entry A-channel queue, executes them against an internal 64-bit-wide register memory, and returns D-channel responses.
- Used as a small scratchpad / test memory behind the A-channel queue in the uncore.
- Single-beat only (size <= 3); one response in flight, with back-to-back acceptance when D drains.

Parameters:
- BASE_ADDR, 33'h0_0001_0000, byte base address of the memory window.
- DEPTH, 16, number of 64-bit words; power of two, >= 2.
- SOURCE_W, 5, width of source/ID fields.

Ports:
- clock  in  1  clock
- reset  in  1  reset
- a_ready  out  1  A-channel ready
- a_valid  in  1  A-channel valid
- a_opcode  in  3  TL A opcode
- a_param  in  3  ignored
- a_size  in  4  log2 bytes
- a_source  in  SOURCE_W  request ID
- a_address  in  33  byte address
- a_mask  in  8  byte lane mask
- a_data  in  64  write data
- a_corrupt  in  1  write data corrupt
- d_ready  in  1  D-channel ready
- d_valid  out  1  D-channel valid
- d_opcode  out  3  TL D opcode
- d_param  out  2  always 0
- d_size  out  4  echo of a_size
- d_source  out  SOURCE_W  echo of a_source
- d_sink  out  1  always 0
- d_denied  out  1  request rejected
- d_data  out  64  read data
- d_corrupt  out  1  read data invalid

Behaviour:
- Reset: reset, synchronous, active-high; clock clock. During and after reset: d_valid=0, all d_* regs 0, every memory word 0, a_ready=1 from the first cycle after reset deasserts.
- Handshake: a_ready = ~d_valid | d_ready. A fire = a_valid & a_ready. D fire = d_valid & d_ready.
- Latency: response appears exactly 1 cycle after A fire.
- d_valid state transitions at each clock edge:
  - A fire: d_valid <= 1 and the d_* response regs load.
  - D fire without A fire: d_valid <= 0.
  - Otherwise: d_valid and all d_* hold. Outputs stay stable while d_valid & ~d_ready.
- Simultaneous D fire and A fire: the new response replaces the old one with no bubble, giving 1 request per cycle sustained.
- Decode, combinational at A fire:
  - in_range = BASE_ADDR <= a_address < BASE_ADDR + DEPTH*8.
  - aligned = (a_size <= 3) and the low a_size address bits are zero.
  - idx = (a_address - BASE_ADDR)[log2(DEPTH)+2:3].
  - ok = in_range & aligned.
- Response by a_opcode:
  - Get(4): d_opcode=AccessAckData(1), d_data = mem[idx], d_denied=~ok, d_corrupt=~ok.
  - PutFullData(0) / PutPartialData(1): d_opcode=AccessAck(0), d_denied = ~ok | a_corrupt. Bytes with a_mask[i]=1 are written at the A-fire edge only if ok & ~a_corrupt.
  - ArithmeticData(2) / LogicalData(3): AccessAckData, d_denied=1, d_corrupt=1, no write.
  - Intent(5): HintAck(2), d_denied=0.
  - 6 / 7: AccessAck, d_denied=1.
- d_data: 0 for all non-data responses and for any denied response.
- Memory read happens at A fire, before that edge's write; only one request is accepted per cycle. A Get accepted the cycle after a Put to the same word returns the new data.
- Reset asserted mid-transaction: the pending response is dropped, d_valid=0 on the next cycle, and memory clears.
- a_param and a_mask are not checked for protocol legality.
- Width: address subtraction is 33-bit unsigned. An address below BASE_ADDR is out of range and must not alias.

Decomposition:
- Shared package tl_pkg holds:
  - A opcode constants: GET=4, PUT_FULL=0, PUT_PARTIAL=1, ARITH=2, LOGIC=3, INTENT=5.
  - D opcode constants: ACCESS_ACK=0, ACCESS_ACK_DATA=1, HINT_ACK=2.
  - TL_ADDR_W=33, TL_DATA_W=64, TL_MASK_W=8.
- One combinational sub-module, tl_a_decode, maps opcode/address/size to ok, idx, d_opcode, denied, corrupt and write-enable.
- The top level holds the response register and the memory array.

Test Plan:
- Reset, then Get at 0x10008 with source 3 -> next cycle d_valid=1, d_opcode=1, d_source=3, d_data=0, d_denied=0.
- PutFull 0x10010, data 64'hDEADBEEF_01234567, mask FF, then Get 0x10010 on the following cycle with d_ready=1 throughout -> AccessAck, then AccessAckData with data DEADBEEF_01234567, one response per cycle, a_ready never drops.
- PutPartial 0x10010, mask 0x0F, data 64'h0_AAAAAAAA, then Get -> data DEADBEEF_AAAAAAAA.
- Get at 0x10080 (just past DEPTH=16), and Get at 0x0FFF8 -> both d_denied=1, d_corrupt=1, d_data=0. Memory is unchanged.
- Hold d_ready=0 for 5 cycles after a Get -> a_ready=0, d_* stable all 5 cycles. Then d_ready=1 with a_valid=1 -> the next response appears with no idle cycle.
- ArithmeticData request -> AccessAckData, denied=1, corrupt=1, no write. Assert reset while d_valid=1 -> next cycle d_valid=0 and a Get of any word returns 0.
